// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch
//
// Instruction fetch unit with a small prefetch queue. A fetch PC walks
// forward one word per issued request; each request goes to a synchronous
// instruction ROM whose word comes back one cycle after the request cycle.
// Returned words are buffered together with their PC and presented to the
// decode stage on a valid/ready handshake. A redirect (branch, jump, trap)
// empties the queue, kills every outstanding request and restarts fetch at
// the new target.
//
// Parameters
//   XLEN      data/address width in bits
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports
//   clk             in   clock, all state on the rising edge
//   rst             in   asynchronous active-low reset
//   redirect_valid  in   flush and restart fetch at redirect_pc
//   redirect_pc     in   new fetch address, low two bits ignored
//   rom_req         out  registered read request to the ROM
//   rom_addr        out  registered byte address of the requested word
//   rom_data        in   ROM word, valid the cycle after rom_req was high
//   inst_valid      out  head entry available to decode
//   inst            out  head instruction word
//   inst_pc         out  PC of the head instruction
//   inst_ready      in   decode accepts the head entry this cycle
// ---------------------------------------------------------------------------
module ifu_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            rom_req,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    // Credit sum needs headroom for count plus two outstanding requests.
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            rom_req_q,  rom_req_d;
    logic [XLEN-1:0] rom_addr_q, rom_addr_d;
    // Set while rom_data carries the word for last cycle's request.
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [XLEN-1:0] last_inst_q;
    logic [XLEN-1:0] last_pc_q;

    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    // Address of the word currently arriving on rom_data.
    logic [XLEN-1:0] resp_pc_q;

    logic            push;
    logic            pop;
    logic            can_issue;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_base;
    logic            queue_nonempty;

    // The two low bits of the redirect target are forced to zero.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
    assign queue_nonempty = (count_q != '0);

    // Queue entries plus both outstanding request stages must fit, so a
    // returning word can never find the queue full.
    assign credit_used = {1'b0, count_q}
                       + {{CW{1'b0}}, rom_req_q}
                       + {{CW{1'b0}}, inflight_q};
    assign can_issue   = (credit_used < DEPTH_C);

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rom_req    = rom_req_q;
    assign rom_addr   = rom_addr_q;
    assign inst_valid = queue_nonempty & ~redirect_valid;
    // When empty, present the last head seen so the outputs never carry
    // stale or uninitialised queue storage.
    assign inst       = queue_nonempty ? inst_mem[rd_ptr_q] : last_inst_q;
    assign inst_pc    = queue_nonempty ? pc_mem[rd_ptr_q]   : last_pc_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rom_req_d  = 1'b0;
        rom_addr_d = rom_addr_q;
        inflight_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (redirect_valid) begin
            // Restart: drop queue contents, the arriving word and the
            // request on rom_req this cycle; issue the new target at once.
            rom_req_d  = 1'b1;
            rom_addr_d = redirect_base;
            fetch_pc_d = redirect_base + XLEN'(4);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            push       = inflight_q;
            pop        = inst_valid & inst_ready;
            inflight_d = rom_req_q;

            if (can_issue) begin
                rom_req_d  = 1'b1;
                rom_addr_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            rom_req_q   <= 1'b0;
            rom_addr_q  <= RESET_PC;
            inflight_q  <= 1'b0;
            resp_pc_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_inst_q <= '0;
            last_pc_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            inflight_q <= inflight_d;
            resp_pc_q  <= rom_addr_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (queue_nonempty) begin
                last_inst_q <= inst_mem[rd_ptr_q];
                last_pc_q   <= pc_mem[rd_ptr_q];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Queue storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only read while the
    // count says it holds a word written since reset or the last flush.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= rom_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_prefetch
//
// Bench for ifu_prefetch (DEPTH=4). A behavioural ROM returns
// 0x1000 + (addr >> 2) one cycle after each request. The reference model
// keeps the expected decode stream as a queue of (pc, word) pairs plus a
// list of outstanding ROM requests with their age, and applies the fetch,
// credit, redirect and reset rules directly. Directed scenarios cover reset,
// streaming, backpressure, redirects and wrap; a random phase follows.
// ---------------------------------------------------------------------------
module tb_ifu_prefetch;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .rom_req       (rom_req),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    function automatic logic [31:0] rom_word(logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // Synchronous ROM; garbage on the bus when no request was made.
    always @(posedge clk) begin
        if (rom_req) rom_data <= rom_word(rom_addr);
        else         rom_data <= $urandom;
    end

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        int          age;   // 0: on rom_req now, 1: word on rom_data now
    } req_t;

    entry_t      m_buf[$];
    req_t        m_pend[$];
    logic [31:0] m_fetch;

    task automatic model_edge(bit rv, logic [31:0] rpc, bit rdy);
        int          used;
        logic [31:0] a;
        req_t        r;
        if (rv) begin
            m_buf.delete();
            m_pend.delete();
            a = {rpc[31:2], 2'b00};
            m_pend.push_back('{addr: a, age: 0});
            m_fetch = a + 32'd4;
        end else begin
            used = m_buf.size() + m_pend.size();
            if (m_buf.size() != 0 && rdy) void'(m_buf.pop_front());
            if (m_pend.size() != 0 && m_pend[0].age == 1) begin
                r = m_pend.pop_front();
                m_buf.push_back('{pc: r.addr, word: rom_word(r.addr)});
            end
            for (int i = 0; i < m_pend.size(); i++) m_pend[i].age++;
            if (used < DEPTH) begin
                m_pend.push_back('{addr: m_fetch, age: 0});
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs,
    // then advance the model on the rising edge. Entered just after a rising
    // edge and returns just after the next one.
    task automatic cycle(bit rv, logic [31:0] rpc, bit rdy);
        bit exp_req;
        bit exp_v;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
        exp_req = (m_pend.size() != 0) && (m_pend[m_pend.size()-1].age == 0);
        check("rom_req", {31'b0, rom_req}, {31'b0, exp_req});
        if (exp_req) check("rom_addr", rom_addr, m_pend[m_pend.size()-1].addr);
        exp_v = (m_buf.size() != 0) && !rv;
        check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_v});
        if (exp_v) begin
            check("inst", inst, m_buf[0].word);
            check("inst_pc", inst_pc, m_buf[0].pc);
        end
        @(posedge clk);
        model_edge(rv, rpc, rdy);
    endtask

    // Asynchronous reset asserted between edges, held for n rising edges,
    // released on a falling edge; the first request follows the next edge.
    task automatic do_reset(int n);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_async_req",   {31'b0, rom_req},    32'd0);
        check("rst_async_addr",  rom_addr,            RESET_PC);
        m_buf.delete();
        m_pend.delete();
        m_fetch = RESET_PC;
        repeat (n) begin
            @(negedge clk);
            check("rst_hold_valid", {31'b0, inst_valid}, 32'd0);
            check("rst_hold_req",   {31'b0, rom_req},    32'd0);
            check("rst_hold_addr",  rom_addr,            RESET_PC);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        rst            = 1'b1;
        #1;
        check("rst_rel_req",  {31'b0, rom_req}, 32'd0);
        check("rst_rel_addr", rom_addr,         RESET_PC);
        check("rst_rel_inst", inst,             32'd0);
        check("rst_rel_pc",   inst_pc,          32'd0);
        @(posedge clk);
        model_edge(1'b0, '0, 1'b1);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        // Reset, then rom_addr 0,4,8,C and streaming with no gaps.
        do_reset(3);
        repeat (8) cycle(1'b0, '0, 1'b1);

        // Backpressure: fill the queue, hold, then drain in order.
        repeat (8) cycle(1'b0, '0, 1'b0);
        repeat (8) cycle(1'b0, '0, 1'b1);

        // Redirect with full queue and requests outstanding.
        repeat (6) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h203, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b1);

        // Redirect coincident with a would-be transfer, then back-to-back.
        cycle(1'b1, 32'h300, 1'b1);
        cycle(1'b1, 32'h40, 1'b1);
        cycle(1'b1, 32'h80, 1'b1);
        repeat (6) cycle(1'b0, '0, 1'b1);

        // Address wrap at the top of the space.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (6) cycle(1'b0, '0, 1'b1);

        // Reset mid-stream with a full queue.
        repeat (6) cycle(1'b0, '0, 1'b0);
        do_reset(2);
        repeat (6) cycle(1'b0, '0, 1'b1);

        // Random traffic with occasional redirects, some near the wrap point.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            bit          rv;
            bit          rdy;
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rv, rpc, rdy);
            if (i == 700) begin
                do_reset(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
